// File: rtl/ram_arbiter.sv
// Two-master single-port RAM arbiter.
// m0 (CPU load/store) normally has priority. m1 (UART loader) is forced through
// once it has been refused for STARVE_LIMIT consecutive requesting cycles.
// Grants are combinational. Command fields pass straight to the RAM in the same cycle.
// Read data returns one cycle later and is steered by a one-bit owner register.
module ram_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // m0: CPU load/store port
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_be,
  output logic                  m0_gnt,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rvalid,
  // m1: UART loader port
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_be,
  output logic                  m1_gnt,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rvalid,
  // RAM port
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_be,
  input  logic [31:0]           ram_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_reg, starve_cnt_next;
  logic       rd_pending_reg, rd_pending_next;
  logic       rd_owner_reg, rd_owner_next;
  logic       m1_starved;

  // Arbitration: m0 wins contention unless m1 has been starved long enough
  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m1_starved = (starve_cnt_reg >= LIMIT);
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (m1_starved) m1_gnt = 1'b1;
        else            m0_gnt = 1'b1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  // RAM command mux: the granted master's fields pass through unmodified
  always_comb begin
    ram_en    = m0_gnt | m1_gnt;
    ram_we    = 1'b0;
    ram_addr  = m0_addr;
    ram_wdata = m0_wdata;
    ram_be    = m0_be;
    if (m1_gnt) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_be    = m1_be;
    end else if (m0_gnt) begin
      ram_we    = m0_we;
    end
  end

  // Next state: starvation counter and the one-deep read-return pipeline
  always_comb begin
    starve_cnt_next = 4'd0;
    if (m1_req && !m1_gnt) begin
      starve_cnt_next = (starve_cnt_reg == 4'd15) ? 4'd15 : starve_cnt_reg + 4'd1;
    end
    rd_pending_next = ram_en && !ram_we;
    rd_owner_next   = m1_gnt;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= 4'd0;
      rd_pending_reg <= 1'b0;
      rd_owner_reg   <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      rd_pending_reg <= rd_pending_next;
      rd_owner_reg   <= rd_owner_next;
    end
  end

  // Read return steering. It is masked by rst so that a read granted just before
  // reset never surfaces.
  always_comb begin
    m0_rvalid = rd_pending_reg && !rd_owner_reg && !rst;
    m1_rvalid = rd_pending_reg &&  rd_owner_reg && !rst;
    m0_rdata  = ram_rdata;
    m1_rdata  = ram_rdata;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter. A behavioural RAM and an arbitration model
// run every cycle. Expected read returns go into a scoreboard queue at grant time.
// They are popped when the DUT should be returning them.
module tb_ram_arbiter;

  localparam int AW = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_be, m1_be;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic [3:0]    ram_be;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } rd_t;
  rd_t sbq[$];

  logic [31:0] mem [logic [31:0]];
  int          m_cnt = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_rdata(ram_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Behavioural RAM: 1-cycle read latency, byte-enabled writes
  always @(posedge clk) begin
    if (ram_en && !ram_we) ram_rdata <= mem_rd(ram_addr);
    if (ram_en && ram_we) begin
      logic [31:0] w;
      w = mem_rd(ram_addr);
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
      mem[ram_addr] = w;
    end
  end

  // Per-cycle monitor: arbitration model, pass-through, exclusivity, read scoreboard
  always @(negedge clk) begin
    logic e0, e1;
    rd_t  r;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (m_cnt >= LIM) e1 = 1'b1;
        else              e0 = 1'b1;
      end else begin
        e0 = m0_req;
        e1 = m1_req;
      end
    end
    check("gnt_excl", 64'(m0_gnt & m1_gnt), 64'd0);
    check("ram_en_or", 64'(ram_en), 64'(m0_gnt | m1_gnt));
    check("m0_gnt", 64'(m0_gnt), 64'(e0));
    check("m1_gnt", 64'(m1_gnt), 64'(e1));
    if (e0 || e1) begin
      check("ram_we", 64'(ram_we), 64'(e1 ? m1_we : m0_we));
      check("ram_addr", 64'(ram_addr), 64'(e1 ? m1_addr : m0_addr));
      check("ram_be", 64'(ram_be), 64'(e1 ? m1_be : m0_be));
      if (e1 ? m1_we : m0_we)
        check("ram_wdata", 64'(ram_wdata), 64'(e1 ? m1_wdata : m0_wdata));
    end else begin
      check("ram_we_idle", 64'(ram_we), 64'd0);
    end
    // read returns
    if (sbq.size() > 0 && !rst) begin
      r = sbq.pop_front();
      check("m0_rvalid", 64'(m0_rvalid), 64'(!r.owner));
      check("m1_rvalid", 64'(m1_rvalid), 64'(r.owner));
      check("rdata", 64'(r.owner ? m1_rdata : m0_rdata), 64'(r.data));
    end else begin
      sbq.delete();
      check("m0_rvalid_idle", 64'(m0_rvalid), 64'd0);
      check("m1_rvalid_idle", 64'(m1_rvalid), 64'd0);
    end
    // model update
    if (rst) m_cnt = 0;
    else if (m1_req && !e1) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
    else m_cnt = 0;
    if (e0 || e1) begin
      logic        we;
      logic [31:0] a;
      we = e1 ? m1_we : m0_we;
      a  = e1 ? m1_addr : m0_addr;
      if (!we) begin
        r.owner = e1;
        r.data  = mem_rd(a);
        sbq.push_back(r);
      end
      $display("txn t=%0t m%0d %s addr=%h wdata=%h", $time, e1 ? 1 : 0, we ? "wr" : "rd", a,
               e1 ? m1_wdata : m0_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_set(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = 4'hF;
  endtask

  task automatic m1_set(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = 4'hF;
  endtask

  initial begin
    logic g0, g1;
    rst = 1'b1;
    ram_rdata = 32'h0;
    m0_set(0, 0, 0, 0);
    m1_set(0, 0, 0, 0);
    mem[32'h1000] = 32'h00ff00ff;
    mem[32'h1008] = 32'h11112222;
    mem[32'h100c] = 32'h33334444;
    mem[32'h1020] = 32'h55556666;
    tick();
    #3;
    check("rst_gnt0", 64'(m0_gnt), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // lone m0 read
    m0_set(1, 0, 32'h1000, 0);
    #3 check("t24_gnt", 64'(m0_gnt), 64'd1);
    tick();
    m0_set(0, 0, 0, 0);
    #3 check("t24_rv", 64'(m0_rvalid), 64'd1);
    check("t24_data", 64'(m0_rdata), 64'h00ff00ff);
    check("t24_m1rv", 64'(m1_rvalid), 64'd0);

    // lone m1 write, then read it back through m0
    tick();
    m1_set(1, 1, 32'h1004, 32'hff00ff00);
    #3 check("t25_gnt", 64'(m1_gnt), 64'd1);
    check("t25_we", 64'(ram_we), 64'd1);
    check("t25_wd", 64'(ram_wdata), 64'hff00ff00);
    tick();
    m1_set(0, 0, 0, 0);
    #3 check("t25_norv", 64'(m0_rvalid | m1_rvalid), 64'd0);
    tick();
    m0_set(1, 0, 32'h1004, 0);
    tick();
    m0_set(0, 0, 0, 0);
    #3 check("t25_readback", 64'(m0_rdata), 64'hff00ff00);

    // continuous contention: m0 x4 then m1, repeating
    tick();
    m0_set(1, 0, 32'h1000, 0);
    m1_set(1, 0, 32'h1008, 0);
    for (int i = 0; i < 15; i++) begin
      #3;
      check("t26_m1", 64'(m1_gnt), 64'((i % 5) == 4));
      check("t26_m0", 64'(m0_gnt), 64'((i % 5) != 4));
      tick();
    end
    m0_set(0, 0, 0, 0);
    m1_set(0, 0, 0, 0);

    // alternating single-cycle reads
    tick();
    m0_set(1, 0, 32'h1008, 0);
    tick();
    m0_set(0, 0, 0, 0);
    m1_set(1, 0, 32'h100c, 0);
    #3 check("t27_rv0", 64'(m0_rvalid), 64'd1);
    check("t27_d0", 64'(m0_rdata), 64'h11112222);
    tick();
    m1_set(0, 0, 0, 0);
    m0_set(1, 0, 32'h1020, 0);
    #3 check("t27_rv1", 64'(m1_rvalid), 64'd1);
    check("t27_d1", 64'(m1_rdata), 64'h33334444);
    tick();
    m0_set(0, 0, 0, 0);
    #3 check("t27_rv2", 64'(m0_rvalid), 64'd1);
    check("t27_d2", 64'(m0_rdata), 64'h55556666);

    // dropped request: m1 loses to m0 then withdraws
    tick();
    m0_set(1, 0, 32'h1000, 0);
    m1_set(1, 1, 32'h1030, 32'hcafef00d);
    tick();
    m0_set(0, 0, 0, 0);
    m1_set(0, 0, 0, 0);
    #3 check("t19_idle", 64'(ram_en), 64'd0);
    tick();
    #3 check("t19_norv", 64'(m1_rvalid), 64'd0);
    check("t19_nowrite", 64'(mem_rd(32'h1030)), 64'd0);

    // reset right after an m0 read grant
    tick();
    m0_set(1, 0, 32'h1000, 0);
    tick();
    m0_set(0, 0, 0, 0);
    rst = 1'b1;
    m1_set(1, 0, 32'h100c, 0);
    for (int i = 0; i < 3; i++) begin
      #3 check("t28_rv", 64'(m0_rvalid), 64'd0);
      check("t28_gnt", 64'(m0_gnt | m1_gnt), 64'd0);
      tick();
    end
    rst = 1'b0;
    #3 check("t28_first", 64'(m1_gnt), 64'd1);
    tick();
    m1_set(0, 0, 0, 0);
    #3 check("t28_rv1", 64'(m1_rvalid), 64'd1);

    // random traffic with held requests and occasional reset
    g0 = 1'b0;
    g1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      rst = ($urandom_range(0, 49) == 0);
      if (!m0_req || g0) begin
        m0_req = ($urandom_range(0, 2) != 0);
        m0_we = $urandom_range(0, 1) == 1;
        m0_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        m0_wdata = $urandom;
        m0_be = 4'($urandom_range(0, 15));
      end
      if (!m1_req || g1) begin
        m1_req = ($urandom_range(0, 2) != 0);
        m1_we = $urandom_range(0, 1) == 1;
        m1_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        m1_wdata = $urandom;
        m1_be = 4'($urandom_range(0, 15));
      end
      #3;
      g0 = m0_gnt;
      g1 = m1_gnt;
    end
    rst = 1'b0;
    m0_set(0, 0, 0, 0);
    m1_set(0, 0, 0, 0);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
